// File: rtl/pea_fire_scheduler.sv
// Firing sequencer for the PEA actor: alternates SETUP_INSTR and INSTR firings and counts completed pairs.
// Optional FC watchdog enabled by defining PEA_SCHED_WATCHDOG_EN.
module pea_fire_scheduler #(
    parameter int         CNT_W       = 8,
    parameter int         TIMEOUT     = 1024,
    parameter logic [1:0] SETUP_INSTR = 2'b00,
    parameter logic [1:0] INSTR       = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] num_pairs,
    input  logic             enable,
    input  logic             fc,
    output logic             invoke,
    output logic [1:0]       next_instr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_count,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, PREP, CHECK, FIRE, WAIT} state_t;

    state_t           state, state_nx;
    logic             phase, phase_nx;
    logic             fc_q;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] count_inc;
    logic             fc_edge;
    logic             start;
    logic             pair_done;
    logic             hit_target;
    logic             wd_expire;

    // Only a fresh FC edge completes a firing; a level left over from the last one is ignored.
    assign fc_edge   = fc & ~fc_q;
    assign count_inc = pair_count + CNT_W'(1);
    assign invoke    = (state == FIRE);
    assign busy      = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        start      = 1'b0;
        pair_done  = 1'b0;
        hit_target = 1'b0;
        case (state)
            IDLE: if (run) begin
                start    = 1'b1;
                phase_nx = 1'b0;
                state_nx = PREP;
            end
            PREP:  state_nx = CHECK;
            CHECK: begin
                if (!run)        state_nx = IDLE;
                else if (enable) state_nx = FIRE;
            end
            FIRE:  state_nx = WAIT;
            WAIT: begin
                if (fc_edge) begin
                    if (!phase) begin
                        phase_nx = 1'b1;
                        state_nx = PREP;
                    end else begin
                        pair_done = 1'b1;
                        if (target != '0 && count_inc == target) begin
                            hit_target = 1'b1;
                            state_nx   = IDLE;
                        end else if (!run) begin
                            state_nx = IDLE;
                        end else begin
                            phase_nx = 1'b0;
                            state_nx = PREP;
                        end
                    end
                end else if (wd_expire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            fc_q       <= 1'b0;
            target     <= '0;
            pair_count <= '0;
            done       <= 1'b0;
            next_instr <= SETUP_INSTR;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            fc_q  <= fc;
            done  <= hit_target;
            if (start) begin
                target     <= num_pairs;
                pair_count <= '0;
            end else if (pair_done) begin
                pair_count <= count_inc;
            end
            // Mode is fixed on PREP entry so enable and the PEA see it stable for the whole firing.
            if (state_nx == PREP && state != PREP)
                next_instr <= phase_nx ? INSTR : SETUP_INSTR;
        end
    end

`ifdef PEA_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + WD_W'(1) : '0;
            if (start)
                timeout_err <= 1'b0;
            else if (wd_expire && !fc_edge)
                timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
